ip_uart_rx_inst: RTL and testbench
==================================

IP_UART_RX_INST -- requirements
Module: ip_uart_rx_inst

Interface
REQ-001 Parameter clk_freq, default 27000000, system clock frequency in Hz.
REQ-002 Parameter uart_freq, default 115200, serial bit rate in bit/s.
REQ-003 clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  Z80 bus-sample strobe; bus inputs are qualified only when it is 1.
REQ-006 iorq_n  input  1  Z80 I/O request, active low.
REQ-007 wr_n  input  1  Z80 write strobe, active low.
REQ-008 rd_n  input  1  Z80 read strobe, active low.
REQ-009 a  input  8  Z80 I/O address, low byte.
REQ-010 d  input  8  Z80 write data.
REQ-011 q  output  8  read data; 8'h00 when not decoded.
REQ-012 q_en  output  1  1 while this block drives q.
REQ-013 uart_rx  input  1  asynchronous serial input; idles high.

Function
REQ-014 Decode is !iorq_n and {a[7:1],1'b0}==8'h12; port 0x12 is DATA and port 0x13 is STATUS.
REQ-015 q_en = decode && !rd_n, combinational; q is 8'h00 whenever q_en is 0.
REQ-016 DATA read returns the FIFO head byte, or 8'hFF when the FIFO is empty.
REQ-017 STATUS read returns {overrun, framing_err, 5'd0, rx_ready}, where rx_ready means the FIFO is not empty.
REQ-018 uart_rx passes through a 2-flop synchronizer before any use, adding 2 clk of latency.
REQ-019 DIV = clk_freq/uart_freq, truncated (234 at defaults); HALF = DIV/2 (117).
REQ-020 RX FSM states are IDLE, START, DATA, STOP, with a bit counter 0..7 and a baud down-counter.
REQ-021 IDLE -> START on a synchronized falling edge (previous 1, current 0); the baud counter loads HALF-1.
REQ-022 START, baud counter 0: line 0 -> DATA (counter loads DIV-1, bit=0); line 1 -> IDLE (glitch, nothing recorded).
REQ-023 DATA, baud counter 0: the line value is shifted in LSB first and the counter reloads DIV-1; after bit 7 -> STOP.
REQ-024 STOP, baud counter 0: line 1 -> push the byte; line 0 -> discard the byte and set framing_err; either way -> IDLE.
REQ-025 A pushed byte is visible on DATA and rx_ready on the clk edge after the stop sample.
REQ-026 A push with the FIFO full drops the byte and sets overrun.
REQ-027 Pop occurs on the first enable cycle in which rd_n=1 after a DATA-port read was held active (rd_hold set); the pop is one per read cycle, and a pop on an empty FIFO is ignored.
REQ-028 Simultaneous pop and push when full: both are performed, overrun is not set, and the count is unchanged.
REQ-029 A STATUS write (enable, decode, a[0]=1, latched wr_n=0) clears any flag whose d bit is 1: d[7] clears overrun, d[6] clears framing_err.
REQ-030 DATA-port writes are ignored.
REQ-031 FIFO pointers wrap modulo depth; a flag set and a flag clear in the same cycle resolve as set.

Reset
REQ-032 Reset 1 forces: FSM IDLE, counters 0, FIFO empty, flags 0, synchronizer 1s, rd_hold 0.
REQ-033 A reset mid-frame abandons the frame with no push and no flag.
REQ-034 q and q_en depend only on the bus and state; with the bus idle they are 8'h00 and 0.

Configuration
REQ-035 Macro IP_UART_RX_FIFO_EN defined: the FIFO is 4 entries deep.
REQ-036 Macro IP_UART_RX_FIFO_EN undefined: a single holding register is used (depth 1), with otherwise identical behaviour and flags.

Verification
REQ-037 Frame 0x5A at 115200 baud, then STATUS read -> 8'h01; DATA read -> 8'h5A; STATUS read again -> 8'h00.
REQ-038 Low pulse of 50 clk on uart_rx -> no push, STATUS stays 8'h00.
REQ-039 Frame 0xA5 with stop bit 0 -> STATUS 8'h40, FIFO empty; write 8'h40 to port 0x13 -> STATUS 8'h00.
REQ-040 With FIFO_EN: 5 frames 0x01..0x05 with no reads -> STATUS 8'h81; DATA reads return 0x01..0x04, then 8'hFF.
REQ-041 Without FIFO_EN: 2 frames 0x11,0x22 -> DATA reads return 0x11, then 8'hFF; overrun is set.
REQ-042 Reset asserted during bit 4 of a frame -> after release, STATUS 8'h00, and the next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/ip_uart_rx_inst.sv
// UART receiver behind a Z80 I/O port pair: 0x12 = DATA (receive FIFO head), 0x13 = STATUS.
// Define IP_UART_RX_FIFO_EN for a 4-entry receive FIFO; otherwise a single holding register is used.
module ip_uart_rx_inst #(
  parameter int clk_freq  = 27000000,
  parameter int uart_freq = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       iorq_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic [7:0] a,
  input  logic [7:0] d,
  output logic [7:0] q,
  output logic       q_en,
  input  logic       uart_rx,
  output logic [1:0] dbg_state
);

  localparam int DIV  = clk_freq / uart_freq;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
`ifdef IP_UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [1:0]      sync_q;
  logic            rx_prev;
  logic            rx_s;
  logic            push_stb;
  logic [7:0]      push_data;
  logic            frame_err_stb;

  logic [7:0]      mem [1 << PW];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [NW-1:0]   count;
  logic            overrun;
  logic            framing_err;
  logic            rd_hold;

  logic            decode;
  logic            rd_data_act;
  logic            pop_evt;
  logic            status_wr;
  logic            fifo_full;
  logic            fifo_nempty;
  logic            do_pop;
  logic            do_push;
  logic            overrun_set;
  logic            unused_d;

  assign dbg_state = state;
  assign unused_d  = ^d[5:0];
  assign rx_s      = sync_q[1];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Line synchronizer plus one extra stage for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], uart_rx};
      rx_prev <= sync_q[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      push_stb      <= 1'b0;
      push_data     <= '0;
      frame_err_stb <= 1'b0;
    end else begin
      push_stb      <= 1'b0;
      frame_err_stb <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_prev && !rx_s) begin
            state    <= S_START;
            baud_cnt <= CW'(HALF - 1);
          end
        end
        S_START: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else if (!rx_s) begin
            state    <= S_DATA;
            baud_cnt <= CW'(DIV - 1);
            bit_cnt  <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            shreg    <= {rx_s, shreg[7:1]};
            baud_cnt <= CW'(DIV - 1);
            if (bit_cnt == 3'd7) state <= S_STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            if (rx_s) begin
              push_stb  <= 1'b1;
              push_data <= shreg;
            end else begin
              frame_err_stb <= 1'b1;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign decode      = !iorq_n && ({a[7:1], 1'b0} == 8'h12);
  assign rd_data_act = enable && decode && !rd_n && !a[0];
  assign pop_evt     = enable && rd_n && rd_hold;
  assign status_wr   = enable && decode && a[0] && !wr_n;
  assign fifo_full   = (count == NW'(DEPTH));
  assign fifo_nempty = (count != '0);
  assign do_pop      = pop_evt && fifo_nempty;
  // A full FIFO still accepts a byte when a pop frees the head in the same cycle
  assign do_push     = push_stb && (!fifo_full || do_pop);
  assign overrun_set = push_stb && fifo_full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
      rd_hold     <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (rd_data_act)  rd_hold <= 1'b1;
      else if (pop_evt) rd_hold <= 1'b0;

      if (overrun_set)              overrun <= 1'b1;
      else if (status_wr && d[7])   overrun <= 1'b0;
      if (frame_err_stb)            framing_err <= 1'b1;
      else if (status_wr && d[6])   framing_err <= 1'b0;
    end
  end

  always_comb begin
    q_en = decode && !rd_n;
    q    = 8'h00;
    if (q_en) begin
      if (a[0]) q = {overrun, framing_err, 5'd0, fifo_nempty};
      else      q = fifo_nempty ? mem[rd_ptr] : 8'hFF;
    end
  end

endmodule

// File: tb/tb_ip_uart_rx_inst.sv
// Randomized bench for ip_uart_rx_inst: reads are scored by a monitor against a queue-based model.
module tb_ip_uart_rx_inst;

  localparam int DIV = 27000000 / 115200;
`ifdef IP_UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       iorq_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       rd_n = 1'b1;
  logic [7:0] a = 8'h00;
  logic [7:0] d = 8'h00;
  logic [7:0] q;
  logic       q_en;
  logic       uart_rx = 1'b1;
  logic [1:0] dbg_state;

  ip_uart_rx_inst dut (
    .clk(clk), .reset(reset), .enable(enable), .iorq_n(iorq_n), .wr_n(wr_n),
    .rd_n(rd_n), .a(a), .d(d), .q(q), .q_en(q_en), .uart_rx(uart_rx),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: received bytes and sticky flags
  logic [7:0] mdl_q[$];
  logic       mdl_ovr = 1'b0;
  logic       mdl_fe = 1'b0;

  logic [7:0] exp_q[$];
  string      name_q[$];
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    uart_rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(DIV);
    end
    uart_rx = stop_ok;
    tick(DIV);
    uart_rx = 1'b1;
    tick(20);
    if (!stop_ok) mdl_fe = 1'b1;
    else if (mdl_q.size() < DEPTH) mdl_q.push_back(b);
    else mdl_ovr = 1'b1;
  endtask

  task automatic read_port(input logic [7:0] addr, input string name);
    logic [7:0] exp;
    if (addr[0]) exp = {mdl_ovr, mdl_fe, 5'd0, mdl_q.size() != 0};
    else exp = (mdl_q.size() != 0) ? mdl_q[0] : 8'hFF;
    exp_q.push_back(exp);
    name_q.push_back(name);
    iorq_n = 1'b0;
    a = addr;
    rd_n = 1'b0;
    tick(3);
    rd_n = 1'b1;
    iorq_n = 1'b1;
    tick(3);
    if (!addr[0] && mdl_q.size() != 0) void'(mdl_q.pop_front());
  endtask

  task automatic write_port(input logic [7:0] addr, input logic [7:0] data);
    iorq_n = 1'b0;
    a = addr;
    d = data;
    wr_n = 1'b0;
    tick(2);
    wr_n = 1'b1;
    iorq_n = 1'b1;
    tick(2);
    if (addr == 8'h13) begin
      if (data[7]) mdl_ovr = 1'b0;
      if (data[6]) mdl_fe = 1'b0;
    end
  endtask

  // Monitor: one comparison per read cycle, on the rising edge of q_en
  logic q_en_d = 1'b0;
  always @(negedge clk) begin
    if (q_en && !q_en_d) begin
      if (exp_q.size() == 0) check("unexpected_read", q, 8'hxx);
      else check(name_q.pop_front(), q, exp_q.pop_front());
    end
    q_en_d <= q_en;
  end

  initial begin
    logic [7:0] b;
    logic       ok;
    int         budget;

    tick(5);
    check("reset_q", q, 8'h00);
    check("reset_q_en", {7'd0, q_en}, 8'h00);
    check("reset_state", {6'd0, dbg_state}, 8'h00);
    reset = 1'b0;
    tick(10);
    read_port(8'h13, "status_after_reset");

    send_frame(8'h5A, 1'b1);
    read_port(8'h13, "status_5a");
    read_port(8'h12, "data_5a");
    read_port(8'h13, "status_5a_drained");

    uart_rx = 1'b0;
    tick(50);
    uart_rx = 1'b1;
    tick(2 * DIV);
    read_port(8'h13, "status_glitch");
    read_port(8'h12, "data_glitch_empty");

    send_frame(8'hA5, 1'b0);
    read_port(8'h13, "status_framing");
    write_port(8'h13, 8'h40);
    read_port(8'h13, "status_fe_cleared");

`ifdef IP_UART_RX_FIFO_EN
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
`else
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
`endif
    read_port(8'h13, "status_overrun");
    for (int i = 0; i <= DEPTH; i++) read_port(8'h12, "data_drain");
    write_port(8'h12, 8'hAB);
    read_port(8'h13, "status_after_data_write");
    write_port(8'h13, 8'h80);
    read_port(8'h13, "status_ovr_cleared");

    // Reset in the middle of bit 4
    b = 8'h96;
    uart_rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      tick(DIV);
    end
    uart_rx = b[4];
    tick(DIV / 2);
    reset = 1'b1;
    uart_rx = 1'b1;
    tick(3);
    check("midframe_reset_state", {6'd0, dbg_state}, 8'h00);
    reset = 1'b0;
    mdl_q.delete();
    mdl_ovr = 1'b0;
    mdl_fe = 1'b0;
    tick(10);
    read_port(8'h13, "status_after_midframe_reset");
    send_frame(8'h3C, 1'b1);
    read_port(8'h12, "data_3c");

    for (int it = 0; it < 8; it++) begin
      b = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok);
      if ($urandom_range(0, 1) == 1) read_port(8'h12, "rand_data");
      read_port(8'h13, "rand_status");
      if ($urandom_range(0, 2) == 0) write_port(8'h13, 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i <= DEPTH; i++) read_port(8'h12, "final_drain");
    read_port(8'h13, "final_status");

    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      tick(1);
      budget++;
    end
    check("scoreboard_empty", 8'(exp_q.size()), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
